nco_sweep_ctrl: RTL and testbench

Frequency-sweep scheduler for the NCO. It sits beside the main control FSM and drives the NCO frequency step through a programmed staircase: start value, increment, stop value, and a dwell time per step. It also issues run start/stop pulses, so a complete sweep runs without software stepping each frequency.

---
 rtl/nco_sweep_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Purpose  : Frequency-sweep scheduler for the NCO. Walks the NCO step word
//            through a staircase (start, +incr, ... up to stop), holding each
//            value for a programmed dwell time, and issues run start/stop
//            pulses so that a whole sweep runs without software stepping.
// Ports    : clk, rst (async, active-high)
//            cfg_start_step_i / cfg_stop_step_i / cfg_incr_i  - staircase
//            cfg_dwell_i (0 treated as 1), cfg_cont_i (continuous mode)
//            sweep_start_i (level, idle only), sweep_abort_i
//            nco_freq_step_o, nco_step_valid_o, nco_run_start_o,
//            nco_run_stop_o, sweep_busy_o, sweep_done_o, sweep_err_o
// Options  : NCO_SWEEP_PINGPONG_EN - continuous mode bounces between the
//            endpoints instead of wrapping back to start.
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
    parameter int STEP_W  = 14,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STEP_W-1:0]  cfg_start_step_i,
    input  logic [STEP_W-1:0]  cfg_stop_step_i,
    input  logic [STEP_W-1:0]  cfg_incr_i,
    input  logic [DWELL_W-1:0] cfg_dwell_i,
    input  logic               cfg_cont_i,
    input  logic               sweep_start_i,
    input  logic               sweep_abort_i,
    output logic [STEP_W-1:0]  nco_freq_step_o,
    output logic               nco_step_valid_o,
    output logic               nco_run_start_o,
    output logic               nco_run_stop_o,
    output logic               sweep_busy_o,
    output logic               sweep_done_o,
    output logic               sweep_err_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DWELL = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic                 valid_q, valid_d;
    logic                 run_start_q, run_start_d;
    logic                 run_stop_q, run_stop_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;

    // Shadow copies of the configuration, captured on an accepted request
    logic [STEP_W-1:0]    sh_start_q, sh_start_d;
    logic [STEP_W-1:0]    sh_stop_q, sh_stop_d;
    logic [STEP_W-1:0]    sh_incr_q, sh_incr_d;
    logic [DWELL_W-1:0]   sh_dwell_q, sh_dwell_d;
    logic                 sh_cont_q, sh_cont_d;

    logic [DWELL_W-1:0]   w_dwell_eff;
    logic                 w_cfg_bad;
    logic [STEP_W:0]      w_sum;
    logic                 w_sum_over;

    // A dwell of 0 would never expire cleanly; it behaves as 1
    assign w_dwell_eff = (cfg_dwell_i == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : cfg_dwell_i;
    assign w_cfg_bad   = (cfg_incr_i == '0) || (cfg_start_step_i == '0) ||
                         (cfg_start_step_i > cfg_stop_step_i);

    // One extra bit so that a carry out of STEP_W can never look like a
    // small in-range value
    assign w_sum      = {1'b0, step_q} + {1'b0, sh_incr_q};
    assign w_sum_over = (w_sum > {1'b0, sh_stop_q});

`ifdef NCO_SWEEP_PINGPONG_EN
    logic                 dir_q, dir_d;   // 0 = counting up, 1 = counting down
    logic [STEP_W:0]      w_diff;
    logic                 w_diff_under;

    // A borrow shows up in the extra MSB and counts as below start
    assign w_diff       = {1'b0, step_q} - {1'b0, sh_incr_q};
    assign w_diff_under = w_diff[STEP_W] || (w_diff[STEP_W-1:0] < sh_start_q);
`endif

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        valid_d     = 1'b0;
        run_start_d = 1'b0;
        run_stop_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        sh_start_d  = sh_start_q;
        sh_stop_d   = sh_stop_q;
        sh_incr_d   = sh_incr_q;
        sh_dwell_d  = sh_dwell_q;
        sh_cont_d   = sh_cont_q;
`ifdef NCO_SWEEP_PINGPONG_EN
        dir_d       = dir_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Abort in idle is a no-op but still suppresses a coincident start
                if (sweep_start_i && !sweep_abort_i) begin
                    sh_start_d = cfg_start_step_i;
                    sh_stop_d  = cfg_stop_step_i;
                    sh_incr_d  = cfg_incr_i;
                    sh_dwell_d = w_dwell_eff;
                    sh_cont_d  = cfg_cont_i;
                    if (w_cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        step_d      = cfg_start_step_i;
                        valid_d     = 1'b1;
                        run_start_d = 1'b1;
                        cnt_d       = w_dwell_eff;
                        state_d     = S_DWELL;
`ifdef NCO_SWEEP_PINGPONG_EN
                        dir_d       = 1'b0;
`endif
                    end
                end
            end

            S_DWELL: begin
                if (sweep_abort_i) begin
                    step_d     = '0;
                    run_stop_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cnt_q <= {{(DWELL_W-1){1'b0}}, 1'b1}) begin
                    cnt_d = sh_dwell_q;
`ifdef NCO_SWEEP_PINGPONG_EN
                    if (sh_cont_q && dir_q) begin
                        valid_d = 1'b1;
                        if (w_diff_under) begin
                            dir_d  = 1'b0;
                            // Clamp keeps a degenerate start==stop range in bounds
                            step_d = w_sum_over ? sh_stop_q : w_sum[STEP_W-1:0];
                        end else begin
                            step_d = w_diff[STEP_W-1:0];
                        end
                    end else if (!w_sum_over) begin
                        step_d  = w_sum[STEP_W-1:0];
                        valid_d = 1'b1;
                    end else if (sh_cont_q) begin
                        dir_d   = 1'b1;
                        step_d  = w_diff_under ? sh_start_q : w_diff[STEP_W-1:0];
                        valid_d = 1'b1;
                    end else begin
                        step_d     = '0;
                        run_stop_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
`else
                    if (!w_sum_over) begin
                        step_d  = w_sum[STEP_W-1:0];
                        valid_d = 1'b1;
                    end else if (sh_cont_q) begin
                        step_d  = sh_start_q;
                        valid_d = 1'b1;
                    end else begin
                        step_d     = '0;
                        run_stop_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                step_d  = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DWELL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            valid_q     <= 1'b0;
            run_start_q <= 1'b0;
            run_stop_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            sh_start_q  <= '0;
            sh_stop_q   <= '0;
            sh_incr_q   <= '0;
            sh_dwell_q  <= '0;
            sh_cont_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            valid_q     <= valid_d;
            run_start_q <= run_start_d;
            run_stop_q  <= run_stop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            sh_start_q  <= sh_start_d;
            sh_stop_q   <= sh_stop_d;
            sh_incr_q   <= sh_incr_d;
            sh_dwell_q  <= sh_dwell_d;
            sh_cont_q   <= sh_cont_d;
        end
    end

`ifdef NCO_SWEEP_PINGPONG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign nco_freq_step_o  = step_q;
    assign nco_step_valid_o = valid_q;
    assign nco_run_start_o  = run_start_q;
    assign nco_run_stop_o   = run_stop_q;
    assign sweep_busy_o     = busy_q;
    assign sweep_done_o     = done_q;
    assign sweep_err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Purpose  : Self-checking bench for nco_sweep_ctrl. Each scenario pushes the
//            expected per-cycle outputs onto a queue, then drives the
//            stimulus and compares one popped entry per clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;
    localparam int STEP_W  = 14;
    localparam int DWELL_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [STEP_W-1:0]  cfg_start_step_i, cfg_stop_step_i, cfg_incr_i;
    logic [DWELL_W-1:0] cfg_dwell_i;
    logic               cfg_cont_i, sweep_start_i, sweep_abort_i;
    logic [STEP_W-1:0]  nco_freq_step_o;
    logic nco_step_valid_o, nco_run_start_o, nco_run_stop_o;
    logic sweep_busy_o, sweep_done_o, sweep_err_o;

    nco_sweep_ctrl #(.STEP_W(STEP_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_start_step_i(cfg_start_step_i), .cfg_stop_step_i(cfg_stop_step_i),
        .cfg_incr_i(cfg_incr_i), .cfg_dwell_i(cfg_dwell_i), .cfg_cont_i(cfg_cont_i),
        .sweep_start_i(sweep_start_i), .sweep_abort_i(sweep_abort_i),
        .nco_freq_step_o(nco_freq_step_o), .nco_step_valid_o(nco_step_valid_o),
        .nco_run_start_o(nco_run_start_o), .nco_run_stop_o(nco_run_stop_o),
        .sweep_busy_o(sweep_busy_o), .sweep_done_o(sweep_done_o),
        .sweep_err_o(sweep_err_o)
    );

    always #5 clk = ~clk;

    // flags = {valid, run_start, run_stop, busy, done, err}
    typedef struct packed {
        logic [STEP_W-1:0] step;
        logic [5:0]        flags;
    } obs_t;

    obs_t sb[$];
    obs_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic obs_t cur_obs();
        obs_t o;
        o.step  = nco_freq_step_o;
        o.flags = {nco_step_valid_o, nco_run_start_o, nco_run_stop_o,
                   sweep_busy_o, sweep_done_o, sweep_err_o};
        return o;
    endfunction

    task automatic push(input logic [STEP_W-1:0] s, input logic [5:0] f);
        obs_t o;
        o.step  = s;
        o.flags = f;
        sb.push_back(o);
    endtask

    // One step value held n cycles: valid (+run_start) on the first cycle
    task automatic push_hold(input logic [STEP_W-1:0] s, input int n, input logic rs);
        push(s, {1'b1, rs, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 1; k < n; k++) push(s, 6'b000100);
    endtask

    task automatic set_cfg(input int st, input int sp, input int inc, input int dw, input logic c);
        cfg_start_step_i = STEP_W'(st);
        cfg_stop_step_i  = STEP_W'(sp);
        cfg_incr_i       = STEP_W'(inc);
        cfg_dwell_i      = DWELL_W'(dw);
        cfg_cont_i       = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; sweep_start_i = 1'b0; sweep_abort_i = 1'b0;
        set_cfg(0, 0, 0, 0, 1'b0);
        push(0, 6'b000000);
        tick(); tick();
        e = sb.pop_front(); n_cmp++;
        if (cur_obs() !== e) begin
            n_err++;
            $display("FAIL reset: got step=%0d flags=%06b, expected step=%0d flags=%06b", nco_freq_step_o, cur_obs().flags, e.step, e.flags);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        set_cfg(100, 130, 10, 3, 1'b0);
        push_hold(100, 3, 1'b1); push_hold(110, 3, 1'b0);
        push_hold(120, 3, 1'b0); push_hold(130, 3, 1'b0);
        push(0, 6'b001010);
        push(0, 6'b000000);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i == 0);
            if (i == 1) set_cfg(1, 16383, 1, 7, 1'b1);   // must not disturb the running sweep
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL single cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
    endtask

    task automatic test_nonaligned();
        int n;
        set_cfg(100, 125, 10, 3, 1'b0);
        push_hold(100, 3, 1'b1); push_hold(110, 3, 1'b0); push_hold(120, 3, 1'b0);
        push(0, 6'b001010);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i == 0);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL nonaligned cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
    endtask

    task automatic test_continuous();
        int n, abt;
`ifdef NCO_SWEEP_PINGPONG_EN
        set_cfg(10, 30, 10, 1, 1'b1);
        push_hold(10, 1, 1'b1); push_hold(20, 1, 1'b0); push_hold(30, 1, 1'b0);
        push_hold(20, 1, 1'b0); push_hold(10, 1, 1'b0); push_hold(20, 1, 1'b0);
        abt = 6;
`else
        set_cfg(100, 130, 10, 3, 1'b1);
        push_hold(100, 3, 1'b1); push_hold(110, 3, 1'b0);
        push_hold(120, 3, 1'b0); push_hold(130, 3, 1'b0);
        push_hold(100, 2, 1'b0);   // wraps with valid, no run_start
        abt = 14;
`endif
        push(0, 6'b001000);        // abort: stop pulse, no done
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i == 0);
            sweep_abort_i = (i == abt);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL continuous cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
        sweep_abort_i = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        set_cfg(100, 130, 10, 3, 1'b0);
        push_hold(100, 3, 1'b1); push_hold(110, 2, 1'b0);
        push(0, 6'b001000);
        push(0, 6'b000000);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i == 0);
            sweep_abort_i = (i == 5);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL abort cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
        sweep_abort_i = 1'b0;
    endtask

    task automatic test_error();
        int st[3] = '{100, 0, 200};
        int sp[3] = '{130, 130, 130};
        int ic[3] = '{0, 10, 10};
        for (int c = 0; c < 3; c++) begin
            set_cfg(st[c], sp[c], ic[c], 3, 1'b0);
            push(0, 6'b000001);
            push(0, 6'b000000);
            for (int i = 0; i < 2; i++) begin
                sweep_start_i = (i == 0);
                tick();
                e = sb.pop_front(); n_cmp++;
                if (cur_obs() !== e) begin
                    n_err++;
                    $display("FAIL error case%0d cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", c, i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
                end
            end
        end
    endtask

    task automatic test_start_abort_same();
        set_cfg(100, 130, 10, 3, 1'b0);
        push(0, 6'b000000);
        push(0, 6'b000000);
        for (int i = 0; i < 2; i++) begin
            sweep_start_i = (i == 0);
            sweep_abort_i = (i == 0);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL start_abort cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
        sweep_abort_i = 1'b0;
    endtask

    // Top-of-range overflow; start held high throughout so it is ignored in
    // dwell and re-accepted the cycle after returning to idle
    task automatic test_back_to_back();
        int n;
        set_cfg(16380, 16383, 3, 1, 1'b0);
        push_hold(16380, 1, 1'b1); push_hold(16383, 1, 1'b0); push(0, 6'b001010);
        push_hold(16380, 1, 1'b1); push_hold(16383, 1, 1'b0); push(0, 6'b001010);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i < 4);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
        sweep_start_i = 1'b0;
    endtask

    task automatic test_dwell_zero();
        int n;
        set_cfg(5, 6, 1, 0, 1'b0);
        push_hold(5, 1, 1'b1); push_hold(6, 1, 1'b0); push(0, 6'b001010);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            sweep_start_i = (i == 0);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL dwell_zero cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        set_cfg(100, 130, 10, 3, 1'b0);
        push_hold(100, 2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            sweep_start_i = (i == 0);
            tick();
            e = sb.pop_front(); n_cmp++;
            if (cur_obs() !== e) begin
                n_err++;
                $display("FAIL reset_mid cyc%0d: got step=%0d flags=%06b, expected step=%0d flags=%06b", i, nco_freq_step_o, cur_obs().flags, e.step, e.flags);
            end
        end
        // Asynchronous: outputs must clear before the next clock edge
        push(0, 6'b000000);
        #2 rst = 1'b1;
        #1;
        e = sb.pop_front(); n_cmp++;
        if (cur_obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid async: got step=%0d flags=%06b, expected step=%0d flags=%06b", nco_freq_step_o, cur_obs().flags, e.step, e.flags);
        end
        tick();
        rst = 1'b0;
        push(0, 6'b000000);
        tick();
        e = sb.pop_front(); n_cmp++;
        if (cur_obs() !== e) begin
            n_err++;
            $display("FAIL reset_mid after: got step=%0d flags=%06b, expected step=%0d flags=%06b", nco_freq_step_o, cur_obs().flags, e.step, e.flags);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_nonaligned();
        test_continuous();
        test_abort();
        test_error();
        test_start_abort_same();
        test_back_to_back();
        test_dwell_zero();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
